// File: rtl/vga_timing_generator.sv
// VGA raster timing: pixel/line counters with registered sync, active-video
// and line/frame strobes, all decoded from the next-state counts.
module vga_timing_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int CW       = 16
) (
  input  logic          clk_25MHz,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          pix_ce,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          hsync,
  output logic          vsync,
  output logic          video_active,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_ON  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_OFF = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_ON  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_OFF = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic          line_q, line_d;
  logic          frame_q, frame_d;

  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    if (!enable) begin
      h_d = H_LAST;
      v_d = V_LAST;
    end else if (pix_ce) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + ONE;
      end else begin
        h_d = h_q + ONE;
      end
      line_d  = (h_d == '0);
      frame_d = (h_d == '0) && (v_d == '0);
    end
    // decode from next-state so outputs line up with the counts
    hsync_d  = (h_d >= HS_ON && h_d < HS_OFF) ? H_POL : ~H_POL;
    vsync_d  = (v_d >= VS_ON && v_d < VS_OFF) ? V_POL : ~V_POL;
    active_d = (h_d < H_ACT) && (v_d < V_ACT);
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      h_q      <= H_LAST;
      v_q      <= V_LAST;
      hsync_q  <= ~H_POL;
      vsync_q  <= ~V_POL;
      active_q <= 1'b0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
    end
  end

  assign h_count      = h_q;
  assign v_count      = v_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_active = active_q;
  assign line_start   = line_q;
  assign frame_start  = frame_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: a small-raster instance (25x11) and an
// 800x600 positive-polarity instance (1056x628), both driven identically.
module tb_vga_timing_generator;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        hs;
    logic        vs;
    logic        act;
    logic        ls;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, enable, pix_ce;

  logic [15:0] ha, va, hb, vb;
  logic hsa, vsa, aca, lsa, fsa;
  logic hsb, vsb, acb, lsb, fsb;

  int total = 0;
  int bad = 0;

  exp_t qa[$];
  exp_t qb[$];

  int ah, av, bh, bv;

  always #5 clk = ~clk;

  vga_timing_generator #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b0), .CW(16)
  ) u_a (
    .clk_25MHz(clk), .rst_n(rst_n), .enable(enable), .pix_ce(pix_ce),
    .h_count(ha), .v_count(va), .hsync(hsa), .vsync(vsa),
    .video_active(aca), .line_start(lsa), .frame_start(fsa)
  );

  vga_timing_generator #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .H_POL(1'b1), .V_POL(1'b1), .CW(16)
  ) u_b (
    .clk_25MHz(clk), .rst_n(rst_n), .enable(enable), .pix_ce(pix_ce),
    .h_count(hb), .v_count(vb), .hsync(hsb), .vsync(vsb),
    .video_active(acb), .line_start(lsb), .frame_start(fsb)
  );

  function automatic exp_t mk(input int h, input int v,
                              input int ha_, input int hf, input int hs_,
                              input int va_, input int vf, input int vs_,
                              input bit hp, input bit vp,
                              input bit ls, input bit fs);
    exp_t e;
    e.h   = 16'(h);
    e.v   = 16'(v);
    e.hs  = (h >= ha_ + hf && h < ha_ + hf + hs_) ? hp : ~hp;
    e.vs  = (v >= va_ + vf && v < va_ + vf + vs_) ? vp : ~vp;
    e.act = (h < ha_) && (v < va_);
    e.ls  = ls;
    e.fs  = fs;
    return e;
  endfunction

  // Drive one clock, advance the reference model, score the result.
  task automatic step(input logic r, input logic e, input logic c);
    bit lsa_e, fsa_e, lsb_e, fsb_e;
    exp_t ea, eb, ga, gb;
    rst_n = r;
    enable = e;
    pix_ce = c;
    lsa_e = 0; fsa_e = 0; lsb_e = 0; fsb_e = 0;
    if (!r || !e) begin
      ah = 24; av = 10; bh = 1055; bv = 627;
    end else if (c) begin
      if (ah == 24) begin ah = 0; av = (av == 10) ? 0 : av + 1; end
      else ah = ah + 1;
      if (bh == 1055) begin bh = 0; bv = (bv == 627) ? 0 : bv + 1; end
      else bh = bh + 1;
      lsa_e = (ah == 0); fsa_e = (ah == 0) && (av == 0);
      lsb_e = (bh == 0); fsb_e = (bh == 0) && (bv == 0);
    end
    qa.push_back(mk(ah, av, 16, 2, 4, 6, 1, 2, 0, 0, lsa_e, fsa_e));
    qb.push_back(mk(bh, bv, 800, 40, 128, 600, 1, 4, 1, 1, lsb_e, fsb_e));
    @(posedge clk);
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    ga = {ha, va, hsa, vsa, aca, lsa, fsa};
    gb = {hb, vb, hsb, vsb, acb, lsb, fsb};
    total++;
    if (ga !== ea) begin
      bad++;
      $display("FAIL sb_a got h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b want h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b",
               ga.h, ga.v, ga.hs, ga.vs, ga.act, ga.ls, ga.fs,
               ea.h, ea.v, ea.hs, ea.vs, ea.act, ea.ls, ea.fs);
    end
    total++;
    if (gb !== eb) begin
      bad++;
      $display("FAIL sb_b got h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b want h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b",
               gb.h, gb.v, gb.hs, gb.vs, gb.act, gb.ls, gb.fs,
               eb.h, eb.v, eb.hs, eb.vs, eb.act, eb.ls, eb.fs);
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0);
    step(0, 1, 1);
    total++;
    if (ha !== 16'd24 || va !== 16'd10 || hsa !== 1'b1 || vsa !== 1'b1 ||
        aca !== 1'b0 || lsa !== 1'b0 || fsa !== 1'b0) begin
      bad++;
      $display("FAIL reset_a got h=%0d v=%0d hs=%b vs=%b act=%b want 24 10 1 1 0",
               ha, va, hsa, vsa, aca);
    end
    total++;
    if (hb !== 16'd1055 || vb !== 16'd627 || hsb !== 1'b0 || vsb !== 1'b0) begin
      bad++;
      $display("FAIL reset_b got h=%0d v=%0d hs=%b vs=%b want 1055 627 0 0",
               hb, vb, hsb, vsb);
    end
  endtask

  task automatic test_first_edge();
    step(1, 1, 1);
    total++;
    if (ha !== 16'd0 || va !== 16'd0 || fsa !== 1'b1 || lsa !== 1'b1 ||
        aca !== 1'b1) begin
      bad++;
      $display("FAIL first_edge got h=%0d v=%0d fs=%b ls=%b act=%b want 0 0 1 1 1",
               ha, va, fsa, lsa, aca);
    end
  endtask

  task automatic test_line();
    int hs_lo, ls_n, act_n;
    hs_lo = 0; ls_n = 0; act_n = 0;
    for (int i = 0; i < 25; i++) begin
      step(1, 1, 1);
      if (!hsa) hs_lo++;
      if (lsa) ls_n++;
      if (aca) act_n++;
    end
    total++;
    if (hs_lo != 4) begin
      bad++;
      $display("FAIL line_hsync got=%0d want=4", hs_lo);
    end
    total++;
    if (ls_n != 1) begin
      bad++;
      $display("FAIL line_strobes got=%0d want=1", ls_n);
    end
    total++;
    if (act_n != 16) begin
      bad++;
      $display("FAIL line_active got=%0d want=16", act_n);
    end
  endtask

  task automatic test_frame();
    int fs_n, vs_lo, vmax;
    bit wrapped;
    logic [15:0] pv;
    fs_n = 0; vs_lo = 0; vmax = 0; wrapped = 0; pv = va;
    for (int i = 0; i < 550; i++) begin
      step(1, 1, 1);
      if (fsa) fs_n++;
      if (!vsa) vs_lo++;
      if (int'(va) > vmax) vmax = int'(va);
      if (pv == 16'd10 && va == 16'd0) wrapped = 1;
      pv = va;
    end
    total++;
    if (fs_n != 2) begin
      bad++;
      $display("FAIL frame_strobes got=%0d want=2", fs_n);
    end
    total++;
    if (vs_lo != 100) begin
      bad++;
      $display("FAIL frame_vsync got=%0d want=100", vs_lo);
    end
    total++;
    if (vmax != 10 || !wrapped) begin
      bad++;
      $display("FAIL frame_vwrap got vmax=%0d wrap=%0d want 10 1", vmax, wrapped);
    end
  endtask

  task automatic test_pix_ce();
    int first, second, wide;
    bit pls;
    first = -1; second = -1; wide = 0; pls = 0;
    step(1, 0, 1);
    for (int i = 0; i < 1200; i++) begin
      step(1, 1, (i % 2) == 0);
      if (fsa) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (lsa && pls) wide++;
      pls = lsa;
    end
    total++;
    if (second < 0 || second - first != 550) begin
      bad++;
      $display("FAIL ce_period got first=%0d second=%0d want spacing 550",
               first, second);
    end
    total++;
    if (wide != 0) begin
      bad++;
      $display("FAIL ce_strobe_width got wide=%0d want 0", wide);
    end
  endtask

  task automatic test_enable_drop();
    int n;
    n = 0;
    while (!(ah == 12 && av == 3) && n < 400) begin
      step(1, 1, 1);
      n++;
    end
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL en_reach got steps=%0d want <400", n);
    end
    step(1, 0, 1);
    total++;
    if (ha !== 16'd24 || va !== 16'd10 || hsa !== 1'b1 || vsa !== 1'b1 ||
        aca !== 1'b0 || hsb !== 1'b0) begin
      bad++;
      $display("FAIL en_idle got h=%0d v=%0d hs=%b vs=%b act=%b want 24 10 1 1 0",
               ha, va, hsa, vsa, aca);
    end
    step(1, 0, 0);
    step(1, 1, 1);
    total++;
    if (ha !== 16'd0 || va !== 16'd0 || fsa !== 1'b1 || lsa !== 1'b1) begin
      bad++;
      $display("FAIL en_restart got h=%0d v=%0d fs=%b ls=%b want 0 0 1 1",
               ha, va, fsa, lsa);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) step(1, 1, 1);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (ha !== 16'd24 || va !== 16'd10 || hsa !== 1'b1 || vsa !== 1'b1 ||
        hb !== 16'd1055 || vb !== 16'd627 || hsb !== 1'b0 || vsb !== 1'b0 ||
        aca !== 1'b0) begin
      bad++;
      $display("FAIL async_rst got ha=%0d va=%0d hb=%0d vb=%0d hsb=%b vsb=%b",
               ha, va, hb, vb, hsb, vsb);
    end
    step(0, 1, 1);
  endtask

  task automatic test_b_line();
    int hs_hi, ls_n, hmax;
    hs_hi = 0; ls_n = 0; hmax = 0;
    step(1, 0, 1);
    for (int i = 0; i < 2112; i++) begin
      step(1, 1, 1);
      if (hsb) hs_hi++;
      if (lsb) ls_n++;
      if (int'(hb) > hmax) hmax = int'(hb);
    end
    total++;
    if (hs_hi != 256) begin
      bad++;
      $display("FAIL b_hsync got=%0d want=256", hs_hi);
    end
    total++;
    if (ls_n != 2 || hmax != 1055 || vb !== 16'd1) begin
      bad++;
      $display("FAIL b_totals got ls=%0d hmax=%0d v=%0d want 2 1055 1",
               ls_n, hmax, vb);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    pix_ce = 1'b0;
    #2;
    test_reset();
    test_first_edge();
    test_line();
    test_frame();
    test_pix_ce();
    test_enable_drop();
    test_async_reset();
    test_b_line();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Parametrised successor to the standalone vertical line counter.
- Holds the horizontal (pixel) and vertical (line) counters in one block, decodes hsync, vsync and the active-video window, and emits line and frame strobes.
- Sits between the pixel clock and the scope's pixel/trace renderer and the VGA pins.
- Adds programmable timing, sync polarity, a pixel clock-enable and a defined idle state.

Parameters:
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch in pixels.
- H_SYNC, 96: hsync width in pixels.
- H_BP, 48: horizontal back porch in pixels. Must be >= 1.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch in lines.
- V_SYNC, 2: vsync width in lines.
- V_BP, 33: vertical back porch in lines. Must be >= 1.
- H_POL, 0: hsync asserted level.
- V_POL, 0: vsync asserted level.
- CW, 16: width of the count outputs. Must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- clk_25MHz  in  1  pixel clock; all flops on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run enable; low = synchronous return to idle.
- pix_ce  in  1  pixel advance qualifier; tie high for one pixel per clock.
- h_count  out  CW  current pixel column.
- v_count  out  CW  current line.
- hsync  out  1  horizontal sync, polarity per H_POL.
- vsync  out  1  vertical sync, polarity per V_POL.
- video_active  out  1  high when h_count < H_ACTIVE and v_count < V_ACTIVE.
- line_start  out  1  one-cycle strobe when h_count becomes 0.
- frame_start  out  1  one-cycle strobe when (h_count, v_count) becomes (0,0).

Behaviour:
- Definitions: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Valid count ranges are 0..H_TOTAL-1 and 0..V_TOTAL-1. The counter never holds the value V_TOTAL.
- Idle state: h_count = H_TOTAL-1, v_count = V_TOTAL-1. This point lies in both back porches, so:
  - hsync = ~H_POL, vsync = ~V_POL;
  - video_active = 0, line_start = 0, frame_start = 0.
- rst_n low: all registers asynchronously take the idle values above.
- enable low at a clock edge: synchronously load idle values, regardless of pix_ce.
- enable high and pix_ce low: every register holds, and the strobes are forced 0.
- enable high and pix_ce high:
  - h_count increments.
  - At H_TOTAL-1, h_count wraps to 0 and v_count advances; v_count wraps from V_TOTAL-1 to 0.
- Consequence of the idle state: the first advancing edge after idle lands on (0,0) and raises frame_start and line_start together.
- All outputs are registered and decoded from the next-state counts, so every output is consistent with h_count and v_count in the same cycle (zero decode latency, no glitches).
- hsync asserted when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC (default 656..751).
- vsync asserted when V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC (default 490..491). vsync changes on the same edge as h_count = 0.
- Strobes last exactly one clock, even when pix_ce stays high for several clocks.
- Simultaneous enable-low and wrap: enable wins and the block goes to idle.
- rst_n deassertion is synchronised externally; no internal reset synchroniser.

Test Plan:
- Reset, then enable=1 and pix_ce=1 -> first edge gives h=0, v=0, frame_start=1, line_start=1, video_active=1.
- Free run for 800 clocks -> hsync low exactly for h=656..751 (96 clocks); line_start recurs every 800 clocks; video_active high for 640 clocks per visible line.
- Full frame of 420000 clocks -> v wraps 524->0; frame_start once per frame; vsync low for v=490..491 (1600 clocks); v never reads 525.
- pix_ce toggling 1/0 -> counts advance every 2 clocks; strobes stay 1 clock wide; frame period is 840000 clocks.
- enable dropped at h=300, v=200 -> next edge shows h=799, v=524, syncs inactive, active=0. Re-enable -> (0,0) with frame_start.
- rst_n pulsed low mid-line with no clock edge -> outputs go to idle immediately. Rerun with H_POL=1, V_POL=1 and 800x600 timing (40/128/88, 1/4/23) -> totals 1056x628; sync polarity inverted.
